// File: rtl/i_cache_2way_if.sv
// -----------------------------------------------------------------------------
// i_cache_2way_if
//   Fetch-side and imem-side signals of the 2-way instruction cache, grouped
//   into one bundle.
//
//   slave  modport : the cache itself
//   master modport : the environment (fetch unit + imem)
//
//   Fetch side : i_Valid, i_Address, i_Flush  -> cache
//                o_Ready, o_Valid, o_Data     <- cache
//   imem side  : o_MEM_Valid, o_MEM_Address  <- cache
//                i_MEM_Valid, i_MEM_Last, i_MEM_Data -> cache
//
// Handshake semantics:
//   A fetch request is accepted only in a cycle where i_Valid and o_Ready are
//   both high. A hit answers in that same cycle with o_Valid/o_Data. On a miss
//   o_Ready drops and the requester keeps presenting the same request until
//   o_Ready returns, when the request then hits. o_Valid may also pulse while
//   o_Ready is low, carrying the requested word forwarded from the refill.
//   o_MEM_Valid/o_MEM_Address stay constant for a whole refill. Every cycle
//   with i_MEM_Valid high carries one beat, in ascending word order.
//   i_MEM_Last marks the final beat. There is no backpressure toward imem.
// -----------------------------------------------------------------------------
interface i_cache_2way_if #(
  parameter int DATA_WIDTH         = 32,
  parameter int TAG_WIDTH          = 14,
  parameter int INDEX_WIDTH        = 5,
  parameter int BLOCK_OFFSET_WIDTH = 2
);
  localparam int AW = TAG_WIDTH + INDEX_WIDTH + BLOCK_OFFSET_WIDTH + 1;

  logic                  i_Valid;
  logic [AW-1:0]         i_Address;
  logic                  i_Flush;
  logic                  o_MEM_Valid;
  logic [AW-1:0]         o_MEM_Address;
  logic                  i_MEM_Valid;
  logic                  i_MEM_Last;
  logic [DATA_WIDTH-1:0] i_MEM_Data;
  logic                  o_Ready;
  logic                  o_Valid;
  logic [DATA_WIDTH-1:0] o_Data;

  modport slave (
    input  i_Valid, i_Address, i_Flush, i_MEM_Valid, i_MEM_Last, i_MEM_Data,
    output o_MEM_Valid, o_MEM_Address, o_Ready, o_Valid, o_Data
  );

  modport master (
    output i_Valid, i_Address, i_Flush, i_MEM_Valid, i_MEM_Last, i_MEM_Data,
    input  o_MEM_Valid, o_MEM_Address, o_Ready, o_Valid, o_Data
  );
endinterface

// File: rtl/i_cache_2way.sv
// -----------------------------------------------------------------------------
// i_cache_2way
//   Read-only, 2-way set-associative instruction cache with per-set LRU,
//   whole-cache flush and forwarding of the requested word during a refill.
//
// Ports:
//   i_Clk        clock; all state changes on the rising edge
//   i_Reset      synchronous, active-high reset
//   bus          i_cache_2way_if.slave (fetch request/response + imem burst)
//   o_Hit_Count  saturating hit counter    (only with I_CACHE_STATS_EN)
//   o_Miss_Count saturating miss counter   (only with I_CACHE_STATS_EN)
//   o_State      current FSM state (0 READY, 1 MISS, 2 FLUSH), for debug
//
// Optional feature: define I_CACHE_STATS_EN to add the hit/miss counters.
//
// Address layout: bit0 is ignored; [BO:1] word offset; [IX+BO:BO+1] set
// index; the remaining upper bits are the tag.
// -----------------------------------------------------------------------------
module i_cache_2way #(
  parameter int DATA_WIDTH         = 32,
  parameter int TAG_WIDTH          = 14,
  parameter int INDEX_WIDTH        = 5,
  parameter int BLOCK_OFFSET_WIDTH = 2
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  i_cache_2way_if.slave       bus,
`ifdef I_CACHE_STATS_EN
  output logic [31:0]         o_Hit_Count,
  output logic [31:0]         o_Miss_Count,
`endif
  output logic [1:0]          o_State
);

  localparam int AW    = TAG_WIDTH + INDEX_WIDTH + BLOCK_OFFSET_WIDTH + 1;
  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << BLOCK_OFFSET_WIDTH;
  // Offset width is at least one bit so that single-word lines still work.
  localparam int OW    = (BLOCK_OFFSET_WIDTH == 0) ? 1 : BLOCK_OFFSET_WIDTH;
  // The beat counter has to reach WORDS itself, where it saturates.
  localparam int BW    = BLOCK_OFFSET_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_MISS  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Storage: tag/data arrays are plain RAM without reset.
  logic [DATA_WIDTH-1:0] data0_mem [SETS][WORDS];
  logic [DATA_WIDTH-1:0] data1_mem [SETS][WORDS];
  logic [TAG_WIDTH-1:0]  tag0_mem  [SETS];
  logic [TAG_WIDTH-1:0]  tag1_mem  [SETS];

  // LRU bit value = the way to evict next.
  logic [SETS-1:0] valid0_q, valid1_q, lru_q;

  state_t                 state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [OW-1:0]          off_q, off_d;
  logic                   victim_q, victim_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic                   flush_pend_q, flush_pend_d;

  // Request decode.
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [OW-1:0]          req_off;

  assign req_tag = TAG_WIDTH'(bus.i_Address >> (INDEX_WIDTH + BLOCK_OFFSET_WIDTH + 1));
  assign req_idx = INDEX_WIDTH'(bus.i_Address >> (BLOCK_OFFSET_WIDTH + 1));
  assign req_off = (BLOCK_OFFSET_WIDTH == 0) ? '0 : OW'(bus.i_Address >> 1);

  logic                  hit0, hit1;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  victim_sel;

  assign hit0     = valid0_q[req_idx] && (tag0_mem[req_idx] == req_tag);
  assign hit1     = valid1_q[req_idx] && (tag1_mem[req_idx] == req_tag);
  assign hit_data = hit0 ? data0_mem[req_idx][req_off] : data1_mem[req_idx][req_off];
  // Fill an empty way first; only evict by LRU when both ways are occupied.
  assign victim_sel = !valid0_q[req_idx] ? 1'b0 :
                      !valid1_q[req_idx] ? 1'b1 : lru_q[req_idx];

  // Per-cycle action strobes produced by the FSM.
  logic hit_upd, hit_way, miss_start, fill_wr, fill_done, fill_ok, sweep_clr;

  logic                  ready_o, valid_o, mem_valid_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic [AW-1:0]         mem_addr_o;

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    off_d        = off_q;
    victim_d     = victim_q;
    beat_d       = beat_q;
    sweep_d      = sweep_q;
    flush_pend_d = flush_pend_q;
    hit_upd      = 1'b0;
    hit_way      = 1'b0;
    miss_start   = 1'b0;
    fill_wr      = 1'b0;
    fill_done    = 1'b0;
    fill_ok      = 1'b0;
    sweep_clr    = 1'b0;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    mem_valid_o  = 1'b0;
    data_o       = '0;
    mem_addr_o   = '0;

    if (i_Reset) begin
      // Outputs settle to their reset values while reset is held.
      state_d = ST_READY;
      ready_o = 1'b1;
    end else begin
      unique case (state_q)
        ST_READY: begin
          ready_o = 1'b1;
          if (bus.i_Flush) begin
            // Flush wins over a same-cycle request: no response, no LRU touch.
            state_d = ST_FLUSH;
          end else if (bus.i_Valid) begin
            if (hit0 || hit1) begin
              valid_o = 1'b1;
              data_o  = hit_data;
              hit_upd = 1'b1;
              hit_way = !hit0;
            end else begin
              miss_start = 1'b1;
              tag_d      = req_tag;
              idx_d      = req_idx;
              off_d      = req_off;
              victim_d   = victim_sel;
              beat_d     = '0;
              state_d    = ST_MISS;
            end
          end
        end

        ST_MISS: begin
          mem_valid_o  = 1'b1;
          mem_addr_o   = AW'({tag_q, idx_q}) << (BLOCK_OFFSET_WIDTH + 1);
          flush_pend_d = flush_pend_q | bus.i_Flush;
          if (bus.i_MEM_Valid) begin
            // Beats past the end of the line are dropped.
            if (beat_q < BW'(WORDS)) begin
              fill_wr = 1'b1;
              beat_d  = beat_q + 1'b1;
              if (beat_q == BW'(off_q)) begin
                valid_o = 1'b1;
                data_o  = bus.i_MEM_Data;
              end
            end
            if (bus.i_MEM_Last) begin
              fill_done = 1'b1;
              // The line is only usable if exactly WORDS beats arrived.
              fill_ok   = (beat_q == BW'(WORDS - 1));
              beat_d    = '0;
              state_d   = (flush_pend_q || bus.i_Flush) ? ST_FLUSH : ST_READY;
            end
          end
        end

        ST_FLUSH: begin
          sweep_clr = 1'b1;
          sweep_d   = sweep_q + 1'b1;
          if (sweep_q == '1) begin
            flush_pend_d = 1'b0;
            sweep_d      = '0;
            state_d      = ST_READY;
          end
        end

        default: state_d = ST_READY;
      endcase
    end
  end

  // Control state and per-set valid/LRU flops.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= ST_READY;
      tag_q        <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      victim_q     <= 1'b0;
      beat_q       <= '0;
      sweep_q      <= '0;
      flush_pend_q <= 1'b0;
      valid0_q     <= '0;
      valid1_q     <= '0;
      lru_q        <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
      sweep_q      <= sweep_d;
      flush_pend_q <= flush_pend_d;

      if (hit_upd) lru_q[req_idx] <= !hit_way;

      // The victim is invalid for the whole refill, so a reset or short
      // burst cannot leave stale data marked valid.
      if (miss_start) begin
        if (victim_sel) valid1_q[req_idx] <= 1'b0;
        else            valid0_q[req_idx] <= 1'b0;
      end

      if (fill_done) begin
        if (victim_q) valid1_q[idx_q] <= fill_ok;
        else          valid0_q[idx_q] <= fill_ok;
        lru_q[idx_q] <= !victim_q;
      end

      if (sweep_clr) begin
        valid0_q[sweep_q] <= 1'b0;
        valid1_q[sweep_q] <= 1'b0;
        lru_q[sweep_q]    <= 1'b0;
      end
    end
  end

  // Tag/data RAM writes.
  always_ff @(posedge i_Clk) begin
    if (fill_wr) begin
      if (victim_q) data1_mem[idx_q][OW'(beat_q)] <= bus.i_MEM_Data;
      else          data0_mem[idx_q][OW'(beat_q)] <= bus.i_MEM_Data;
    end
    if (fill_done) begin
      if (victim_q) tag1_mem[idx_q] <= tag_q;
      else          tag0_mem[idx_q] <= tag_q;
    end
  end

`ifdef I_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_upd && (hit_cnt_q != '1))     hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_start && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign o_Hit_Count  = hit_cnt_q;
  assign o_Miss_Count = miss_cnt_q;
`endif

  assign bus.o_Ready       = ready_o;
  assign bus.o_Valid       = valid_o;
  assign bus.o_Data        = data_o;
  assign bus.o_MEM_Valid   = mem_valid_o;
  assign bus.o_MEM_Address = mem_addr_o;
  assign o_State           = state_q;

endmodule

// File: tb/tb_i_cache_2way.sv
// -----------------------------------------------------------------------------
// tb_i_cache_2way
//   Directed bench for i_cache_2way with default parameters (22-bit address,
//   4-word lines, 32 sets). Inputs change on the falling edge; outputs are
//   sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_i_cache_2way;

  logic clk;
  logic rst;
  logic [1:0] state;
`ifdef I_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  i_cache_2way_if bus();

  i_cache_2way dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .bus          (bus),
`ifdef I_CACHE_STATS_EN
    .o_Hit_Count  (hit_count),
    .o_Miss_Count (miss_count),
`endif
    .o_State      (state)
  );

  // Clock / reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_Valid     = 1'b0;
    bus.i_Address   = '0;
    bus.i_Flush     = 1'b0;
    bus.i_MEM_Valid = 1'b0;
    bus.i_MEM_Last  = 1'b0;
    bus.i_MEM_Data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready",     bus.o_Ready, 1);
    check("rst_valid",     bus.o_Valid, 0);
    check("rst_mem_valid", bus.o_MEM_Valid, 0);
    check("rst_data",      bus.o_Data, 0);
    check("rst_mem_addr",  bus.o_MEM_Address, 0);
    check("rst_state",     state, 0);
  endtask

  // Counts falling edges with o_Ready low. Call at negedge+1 with idle inputs.
  task automatic count_flush(input string name);
    int cnt;
    cnt = 0;
    while (bus.o_Ready === 1'b0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check(name, cnt, 32);
  endtask

  task automatic hit(input logic [21:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus.i_Valid   = 1'b1;
    bus.i_Address = addr;
    #1;
    check("hit_valid",     bus.o_Valid, 1);
    check("hit_data",      bus.o_Data, exp);
    check("hit_mem_valid", bus.o_MEM_Valid, 0);
    @(posedge clk);
  endtask

  // Presents addr (expected to miss), then drives nbeats beats of base+b.
  task automatic miss_fill(input logic [21:0] addr, input logic [31:0] base,
                           input int nbeats, input int flush_at,
                           input bit do_last, input bit expect_flush);
    int off;
    logic [21:0] line;
    bit fwd;
    off  = int'((addr >> 1) & 22'h3);
    line = addr & ~22'h7;
    @(negedge clk);
    bus.i_Valid   = 1'b1;
    bus.i_Address = addr;
    #1;
    check("miss_req_valid", bus.o_Valid, 0);
    check("miss_req_ready", bus.o_Ready, 1);
    @(posedge clk);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      bus.i_MEM_Valid = 1'b1;
      bus.i_MEM_Data  = base + b;
      bus.i_MEM_Last  = do_last && (b == nbeats - 1);
      bus.i_Flush     = (b == flush_at);
      #1;
      if (b == 0) begin
        check("miss_mem_valid", bus.o_MEM_Valid, 1);
        check("miss_mem_addr",  bus.o_MEM_Address, line);
        check("miss_ready",     bus.o_Ready, 0);
        check("miss_state",     state, 1);
      end
      fwd = (b == off) && (b < 4);
      check("fwd_valid", bus.o_Valid, fwd);
      if (fwd) check("fwd_data", bus.o_Data, base + b);
      @(posedge clk);
    end
    if (do_last) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (expect_flush) count_flush("flush_after_fill_len");
      else begin
        check("fill_exit_ready",     bus.o_Ready, 1);
        check("fill_exit_mem_valid", bus.o_MEM_Valid, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Cold miss: tag 1, set 0, offset 2; word 0xA2 forwarded on 3rd beat.
    miss_fill(22'h000104, 32'hA0, 4, -1, 1'b1, 1'b0);
    hit(22'h000104, 32'hA2);
    // Hit per offset.
    hit(22'h000100, 32'hA0);
    hit(22'h000102, 32'hA1);
    hit(22'h000106, 32'hA3);

    // LRU: tag2 goes into way1; touching tag1 makes tag2 the victim.
    miss_fill(22'h000200, 32'hB0, 4, -1, 1'b1, 1'b0);
    hit(22'h000100, 32'hA0);
    miss_fill(22'h000306, 32'hC0, 4, -1, 1'b1, 1'b0);
    hit(22'h000100, 32'hA0);
    hit(22'h000300, 32'hC0);
    miss_fill(22'h000200, 32'hB0, 4, -1, 1'b1, 1'b0);  // evicts tag1
    hit(22'h000202, 32'hB1);
    miss_fill(22'h000100, 32'hA0, 4, -1, 1'b1, 1'b0);  // evicts tag3
    hit(22'h000104, 32'hA2);
    hit(22'h000202, 32'hB1);

    // Flush alongside a hitting request.
    @(negedge clk);
    bus.i_Flush   = 1'b1;
    bus.i_Valid   = 1'b1;
    bus.i_Address = 22'h000100;
    #1;
    check("flush_blocks_hit", bus.o_Valid, 0);
    check("flush_req_ready",  bus.o_Ready, 1);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    check("flush_state", state, 2);
    count_flush("flush_len");
    miss_fill(22'h000100, 32'hA0, 4, -1, 1'b1, 1'b0);

    // Flush during a fill: fill completes, then a full flush.
    miss_fill(22'h000204, 32'hB0, 4, 1, 1'b1, 1'b1);
    miss_fill(22'h000204, 32'hB0, 4, -1, 1'b1, 1'b0);

    // Reset after two beats.
    miss_fill(22'h000104, 32'hF0, 2, -1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    check("mid_rst_mem_valid", bus.o_MEM_Valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready",     bus.o_Ready, 1);
    check("post_rst_mem_valid", bus.o_MEM_Valid, 0);
    check("post_rst_state",     state, 0);
    miss_fill(22'h000104, 32'hA0, 4, -1, 1'b1, 1'b0);

    // Short burst (Last on beat 2) leaves the line invalid.
    miss_fill(22'h000300, 32'hD0, 2, -1, 1'b1, 1'b0);
    miss_fill(22'h000300, 32'hE0, 4, -1, 1'b1, 1'b0);
    hit(22'h000302, 32'hE1);

    // Over-long burst (5 beats) also leaves the line invalid.
    miss_fill(22'h000400, 32'h50, 5, -1, 1'b1, 1'b0);
    miss_fill(22'h000400, 32'h60, 4, -1, 1'b1, 1'b0);
    hit(22'h000406, 32'h63);

    @(negedge clk);
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
